// File: rtl/ram_arbiter.sv
// Two-port arbiter for a byte-wide synchronous RAM: splits 1-4 byte little-endian
// requests into consecutive byte cycles, round-robin between port A and port B.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [1:0]            a_size,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [31:0]           a_wdata,
    output logic [31:0]           a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [1:0]            b_size,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [31:0]           b_wdata,
    output logic [31:0]           b_rdata,
    output logic                  b_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_data_in,
    output logic                  ram_write_enable,
    input  logic [7:0]            ram_data_out,
    output logic                  busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_READ      = 3'd2;
    localparam logic [2:0] ST_READ_LAST = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic       PORT_A       = 1'b0;
    localparam logic       PORT_B       = 1'b1;

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] sel);
        case (sel)
            2'd0:    get_byte = word[7:0];
            2'd1:    get_byte = word[15:8];
            2'd2:    get_byte = word[23:16];
            2'd3:    get_byte = word[31:24];
            default: get_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] sel,
                                             input logic [7:0] val);
        logic [31:0] r;
        r = word;
        case (sel)
            2'd0:    r[7:0]   = val;
            2'd1:    r[15:8]  = val;
            2'd2:    r[23:16] = val;
            2'd3:    r[31:24] = val;
            default: r = word;
        endcase
        return r;
    endfunction

    logic [2:0]            state_r, state_s;
    logic [1:0]            idx_r, idx_s;
    logic                  grant_r, grant_s;
    logic                  last_grant_r, last_grant_s;
    logic                  write_r, write_s;
    logic [1:0]            size_r, size_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic [31:0]           wdata_r, wdata_s;
    logic [31:0]           a_rdata_r, a_rdata_s;
    logic [31:0]           b_rdata_r, b_rdata_s;
    logic                  a_ack_r, a_ack_s;
    logic                  b_ack_r, b_ack_s;
    logic [ADDR_WIDTH-1:0] ram_address_r, ram_address_s;
    logic [7:0]            ram_data_in_r, ram_data_in_s;
    logic                  ram_we_r, ram_we_s;
    logic                  busy_r, busy_s;
    logic [31:0]           cap_s;
    logic                  cap_en_s;

    // Next-state, capture and output decode; RAM outputs are computed from the next state so they come out of flops.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        write_s      = write_r;
        size_s       = size_r;
        base_s       = base_r;
        wdata_s      = wdata_r;
        a_rdata_s    = a_rdata_r;
        b_rdata_s    = b_rdata_r;
        cap_s        = (grant_r == PORT_B) ? b_rdata_r : a_rdata_r;
        cap_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    if (a_req && b_req) begin
                        grant_s = ~last_grant_r;
                    end else begin
                        grant_s = b_req ? PORT_B : PORT_A;
                    end
                    last_grant_s = grant_s;
                    if (grant_s == PORT_B) begin
                        write_s = b_write;
                        size_s  = b_size;
                        base_s  = b_address;
                        wdata_s = b_wdata;
                    end else begin
                        write_s = a_write;
                        size_s  = a_size;
                        base_s  = a_address;
                        wdata_s = a_wdata;
                    end
                    idx_s = 2'd0;
                    if (write_s) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s  = ST_READ;
                        cap_s    = 32'd0;
                        cap_en_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                idx_s = idx_r + 2'd1;
                if (idx_r == size_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                // RAM data lags the address by one cycle, so byte idx-1 is on ram_data_out now.
                if (idx_r != 2'd0) begin
                    cap_s    = put_byte(cap_s, idx_r - 2'd1, ram_data_out);
                    cap_en_s = 1'b1;
                end else begin
                    cap_en_s = 1'b0;
                end
                idx_s = idx_r + 2'd1;
                if (idx_r == size_r) begin
                    state_s = ST_READ_LAST;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ_LAST: begin
                cap_s    = put_byte(cap_s, size_r, ram_data_out);
                cap_en_s = 1'b1;
                state_s  = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (cap_en_s) begin
            if (grant_s == PORT_B) begin
                b_rdata_s = cap_s;
            end else begin
                a_rdata_s = cap_s;
            end
        end else begin
            cap_en_s = 1'b0;
        end

        a_ack_s = (state_s == ST_DONE) && (grant_s == PORT_A);
        b_ack_s = (state_s == ST_DONE) && (grant_s == PORT_B);
        busy_s  = (state_s != ST_IDLE);

        case (state_s)
            ST_WRITE: begin
                ram_address_s = base_s + {{(ADDR_WIDTH-2){1'b0}}, idx_s};
                ram_data_in_s = get_byte(wdata_s, idx_s);
                ram_we_s      = 1'b1;
            end
            ST_READ: begin
                ram_address_s = base_s + {{(ADDR_WIDTH-2){1'b0}}, idx_s};
                ram_data_in_s = 8'h00;
                ram_we_s      = 1'b0;
            end
            default: begin
                ram_address_s = {ADDR_WIDTH{1'b0}};
                ram_data_in_s = 8'h00;
                ram_we_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= 2'd0;
            grant_r       <= PORT_A;
            last_grant_r  <= PORT_B;
            write_r       <= 1'b0;
            size_r        <= 2'd0;
            base_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= 32'd0;
            a_rdata_r     <= 32'd0;
            b_rdata_r     <= 32'd0;
            a_ack_r       <= 1'b0;
            b_ack_r       <= 1'b0;
            ram_address_r <= {ADDR_WIDTH{1'b0}};
            ram_data_in_r <= 8'h00;
            ram_we_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            grant_r       <= grant_s;
            last_grant_r  <= last_grant_s;
            write_r       <= write_s;
            size_r        <= size_s;
            base_r        <= base_s;
            wdata_r       <= wdata_s;
            a_rdata_r     <= a_rdata_s;
            b_rdata_r     <= b_rdata_s;
            a_ack_r       <= a_ack_s;
            b_ack_r       <= b_ack_s;
            ram_address_r <= ram_address_s;
            ram_data_in_r <= ram_data_in_s;
            ram_we_r      <= ram_we_s;
            busy_r        <= busy_s;
        end
    end

    assign a_rdata          = a_rdata_r;
    assign b_rdata          = b_rdata_r;
    assign a_ack            = a_ack_r;
    assign b_ack            = b_ack_r;
    assign ram_address      = ram_address_r;
    assign ram_data_in      = ram_data_in_r;
    assign ram_write_enable = ram_we_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, transaction table with a
// completion scoreboard, RAM write-byte scoreboard, plus arbitration and reset-abort sequences.
module tb_ram_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_write, b_req, b_write;
    logic [1:0]    a_size, b_size;
    logic [AW-1:0] a_address, b_address;
    logic [31:0]   a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_ack, b_ack;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data_in, ram_data_out;
    logic          ram_write_enable, busy;

    logic [7:0] mem [0:(1<<AW)-1];

    typedef struct { logic port; logic [31:0] rdata; int lat; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic port; logic write; logic [1:0] size; logic [AW-1:0] addr;
                     logic [31:0] wdata; logic [31:0] rdata; } vec_t;

    exp_t        sb_q[$];
    wr_t         wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata [2];

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_size(a_size), .a_address(a_address),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_write(b_write), .b_size(b_size), .b_address(b_address),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every RAM write byte must match the next expected byte, in order.
    always @(negedge clk) begin
        if (ram_write_enable) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %h@%h expected none", ram_data_in, ram_address);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", {20'd0, ram_address}, {20'd0, w.addr});
                check("wr_data", {24'd0, ram_data_in}, {24'd0, w.data});
            end
        end
    end

    task automatic set_port(input logic p, input logic req, input logic wr, input logic [1:0] sz,
                            input logic [AW-1:0] ad, input logic [31:0] wd);
        if (p) begin
            b_req = req; b_write = wr; b_size = sz; b_address = ad; b_wdata = wd;
        end else begin
            a_req = req; a_write = wr; a_size = sz; a_address = ad; a_wdata = wd;
        end
    endtask

    task automatic push_writes(input logic [1:0] sz, input logic [AW-1:0] ad, input logic [31:0] wd);
        for (int i = 0; i <= int'(sz); i++) begin
            wr_t         w;
            logic [31:0] t;
            t      = wd >> (8 * i);
            w.addr = ad + AW'(i);
            w.data = t[7:0];
            wq.push_back(w);
        end
    endtask

    task automatic do_txn(input vec_t v);
        exp_t e;
        logic got;
        logic other;
        e.port  = v.port;
        e.rdata = v.write ? model_rdata[v.port] : v.rdata;
        e.lat   = v.write ? int'(v.size) + 2 : int'(v.size) + 3;
        if (v.write) push_writes(v.size, v.addr, v.wdata);
        sb_q.push_back(e);
        set_port(v.port, 1'b1, v.write, v.size, v.addr, v.wdata);
        got   = 1'b0;
        other = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(posedge clk); #1;
            if ((v.port ? a_ack : b_ack) == 1'b1) other = 1'b1;
            if ((v.port ? b_ack : a_ack) == 1'b1) begin
                exp_t p;
                got = 1'b1;
                p   = sb_q.pop_front();
                set_port(v.port, 1'b0, 1'b0, 2'd0, '0, 32'd0);
                check("latency", k, p.lat);
                check("rdata", p.port ? b_rdata : a_rdata, p.rdata);
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 12 cycles");
            void'(sb_q.pop_front());
            set_port(v.port, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        end
        if (!v.write) model_rdata[v.port] = v.rdata;
        check("other_ack", {31'd0, other}, 32'd0);
        check("other_rdata", v.port ? a_rdata : b_rdata, model_rdata[!v.port]);
        @(posedge clk); #1;
        check("idle_gap_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   acks;
        int   ra, rb;
        logic pend_a, pend_b;
        logic seen_ack;

        vecs[0] = '{1'b0, 1'b1, 2'd3, 12'h010, 32'h12345678, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 2'd3, 12'h010, 32'h0, 32'h12345678};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 12'h011, 32'h0, 32'h00000056};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 12'hFFF, 32'h0000BEEF, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 12'hFFF, 32'h0, 32'h0000BEEF};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 12'h000, 32'h0, 32'h000000BE};
        vecs[6] = '{1'b0, 1'b1, 2'd2, 12'h100, 32'hDEADBEEF, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 12'h100, 32'h0, 32'h00ADBEEF};
        vecs[8] = '{1'b0, 1'b0, 2'd1, 12'h101, 32'h0, 32'h0000ADBE};

        reset = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_ram_address", {20'd0, ram_address}, 32'd0);
        check("rst_ram_data_in", {24'd0, ram_data_in}, 32'd0);
        check("rst_ram_we", {31'd0, ram_write_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Both requesters hold 1-byte writes: grants must go A, B, A, B.
        wq.push_back('{12'h200, 8'hA0});
        wq.push_back('{12'h300, 8'hB0});
        wq.push_back('{12'h201, 8'hA1});
        wq.push_back('{12'h301, 8'hB1});
        sb_q.push_back('{1'b0, 32'd0, 0});
        sb_q.push_back('{1'b1, 32'd0, 0});
        sb_q.push_back('{1'b0, 32'd0, 0});
        sb_q.push_back('{1'b1, 32'd0, 0});
        set_port(1'b0, 1'b1, 1'b1, 2'd0, 12'h200, 32'h000000A0);
        set_port(1'b1, 1'b1, 1'b1, 2'd0, 12'h300, 32'h000000B0);
        acks = 0; ra = 1; rb = 1; pend_a = 1'b0; pend_b = 1'b0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(posedge clk); #1;
            if (pend_a || pend_b) begin
                check("arb_idle_gap", {31'd0, busy}, 32'd0);
                if (pend_a && ra < 2) begin
                    set_port(1'b0, 1'b1, 1'b1, 2'd0, 12'h200 + AW'(ra), 32'h000000A0 + ra);
                    ra++;
                end
                if (pend_b && rb < 2) begin
                    set_port(1'b1, 1'b1, 1'b1, 2'd0, 12'h300 + AW'(rb), 32'h000000B0 + rb);
                    rb++;
                end
                pend_a = 1'b0;
                pend_b = 1'b0;
            end
            if (a_ack || b_ack) begin
                exp_t p;
                p = sb_q.pop_front();
                check("arb_both_ack", {31'd0, a_ack & b_ack}, 32'd0);
                check("arb_grant", {31'd0, b_ack}, {31'd0, p.port});
                acks++;
                if (a_ack) begin pend_a = 1'b1; set_port(1'b0, 1'b0, 1'b0, 2'd0, '0, 32'd0); end
                if (b_ack) begin pend_b = 1'b1; set_port(1'b1, 1'b0, 1'b0, 2'd0, '0, 32'd0); end
            end
        end
        check("arb_ack_count", acks, 32'd4);
        sb_q.delete();
        set_port(1'b0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("arb_wq_drained", wq.size(), 32'd0);

        for (int i = 0; i < 9; i++) do_txn(vecs[i]);
        check("table_wq_drained", wq.size(), 32'd0);

        // Reset after two bytes of a 4-byte write: first two bytes land, no ack.
        do_txn('{1'b0, 1'b1, 2'd3, 12'h020, 32'hAAAAAAAA, 32'h0});
        wq.push_back('{12'h020, 8'h44});
        wq.push_back('{12'h021, 8'h33});
        set_port(1'b0, 1'b1, 1'b1, 2'd3, 12'h020, 32'h11223344);
        @(posedge clk); #1;
        check("abort_busy_accept", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, ram_write_enable}, 32'd0);
        check("abort_a_rdata", a_rdata, 32'd0);
        reset = 1'b1;
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        seen_ack = a_ack | b_ack;
        repeat (4) begin
            @(posedge clk); #1;
            seen_ack = seen_ack | a_ack | b_ack;
        end
        check("abort_no_ack", {31'd0, seen_ack}, 32'd0);
        check("abort_wq_drained", wq.size(), 32'd0);
        do_txn('{1'b0, 1'b0, 2'd3, 12'h020, 32'h0, 32'hAAAA3344});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single byte-wide on-chip RAM (12-bit address, 1-cycle synchronous read, write-enable) between two requesters.
  - Port A: CPU data path.
  - Port B: DMA/loader.
- Turns each 1–4 byte little-endian request into back-to-back byte cycles on the RAM.
- Arbitrates round-robin and holds the grant for the whole multi-byte transaction.

Parameters:
ADDR_WIDTH, 12, RAM byte address width; addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- a_req  input  1  port A request; held with a_* stable until a_ack.
- a_write  input  1  1=write, 0=read.
- a_size  input  2  byte count minus 1 (0..3 → 1..4 bytes).
- a_address  input  ADDR_WIDTH  base byte address.
- a_wdata  input  32  write data; byte i written to base+i.
- a_rdata  output  32  read data; byte i from base+i; unread upper bytes zero.
- a_ack  output  1  one-cycle completion pulse.
- b_req, b_write, b_size, b_address, b_wdata, b_rdata, b_ack: same as port A.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data_in  output  8  to RAM write data.
- ram_write_enable  output  1  to RAM write enable.
- ram_data_out  input  8  from RAM; valid the cycle after a read address is sampled.
- busy  output  1  high in any state except IDLE.

Behaviour:
- **Reset** (reset=0 at an edge):
  - State → IDLE.
  - a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_data_in, ram_write_enable, busy all 0.
  - last_grant = B, so A wins the first tie.
  - Reset mid-transaction aborts it immediately: no ack is issued, and bytes already written stay written.
- **States:** IDLE, WRITE, READ, READ_LAST, DONE.
- **IDLE:**
  - RAM outputs are 0.
  - If exactly one req is high at an edge, latch that port's write/size/address/wdata and set grant.
  - If both are high, grant the port opposite last_grant, then update last_grant.
  - A write request → WRITE; a read request → READ. In both cases idx=0.
- **WRITE:**
  - ram_address = base+idx (mod 2^ADDR_WIDTH), ram_data_in = wdata byte idx, ram_write_enable=1.
  - Each edge increments idx.
  - On the edge where idx==size → DONE.
  - An n-byte write occupies n cycles; ack is high n+1 cycles after the accepting edge's cycle.
- **READ:**
  - ram_address = base+idx, ram_write_enable=0.
  - Each edge: if idx≥1, capture ram_data_out into rdata byte idx-1; then idx increments.
  - On the edge where idx==size → READ_LAST.
- **READ_LAST:**
  - No new address.
  - At the next edge, capture ram_data_out into byte size, then → DONE.
- **Read data:** rdata of the granted port is cleared to 0 at acceptance, then filled byte by byte. The other port's rdata is unchanged.
- **DONE:**
  - Registered ack of the granted port is 1 for exactly this cycle, and rdata is final.
  - req is not sampled in DONE.
  - Next edge → IDLE. The requester must drop or replace req by then.
- **Latency** from the accepting edge:
  - Write of n bytes: ack in cycle n+1.
  - Read of n bytes: ack in cycle n+2.
  - Minimum gap between consecutive transactions: one IDLE cycle.
- **Stability rules:**
  - Requests arriving while busy wait; req is level-held.
  - Changes to the latched port's inputs after acceptance are ignored.
  - rdata holds until the next read completes on that port.
- ram_write_enable is never 1 outside WRITE.

Test Plan:
- Reset, then idle → all outputs 0.
- First simultaneous a_req/b_req → A granted first.
- A write, size=3, addr 0x010, wdata 0x12345678 →
  - Consecutive cycles drive 0x78@0x010, 0x56@0x011, 0x34@0x012, 0x12@0x013 with write_enable=1.
  - a_ack pulses 5th cycle after accept.
- A read, size=3, addr 0x010 → a_rdata=0x12345678 with a_ack in 6th cycle after accept; b_ack stays 0.
- B read, size=0, addr 0x011 → b_rdata=0x00000056, ack in 3rd cycle.
- B write, size=1, addr 0xFFF, wdata 0x0000BEEF → 0xEF@0xFFF, 0xBE@0x000 (wrap). A read of 0xFFF, size=1, returns 0x0000BEEF.
- Both req held continuously, 1-byte writes → grants alternate A, B, A, B. Each ack is followed by one IDLE cycle, and each requester drops req after its ack.
- A write, size=3, to 0x020 (pre-filled 0xAA) with reset=0 after two bytes written →
  - 0x020–0x021 updated, 0x022–0x023 remain 0xAA.
  - No a_ack; state IDLE, busy=0.
